// File: rtl/timer_int_arbiter_pkg.sv
// Shared constants for the timer interrupt arbiter: FSM state encoding,
// default vector of the highest-priority source and the mask register address.
package timer_int_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [15:0] VEC_TOP_DEFAULT   = 16'hFFFC;
    localparam logic [15:0] MASK_ADDR_DEFAULT = 16'h01A0;

endpackage

// File: rtl/timer_int_arbiter_prio_enc.sv
// Highest-set-bit priority encoder: idx is the index of the most significant
// set bit of req, valid is high when any bit is set.
module prio_enc #(
    parameter int N_SRC = 8,
    parameter int IW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Later iterations overwrite earlier ones, so the top-most set bit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_int_arbiter.sv
// Fixed-priority interrupt arbiter between the peripherals and the CPU request
// path. Define INTARB_MASK_EN to add a memory-mapped source enable mask.
module timer_int_arbiter
    import timer_int_arbiter_pkg::*;
#(
    parameter int               N_SRC     = 8,
    parameter logic [15:0]      VEC_TOP   = VEC_TOP_DEFAULT,
    parameter logic [N_SRC-1:0] NMI_MASK  = '0,
    parameter logic [15:0]      MASK_ADDR = MASK_ADDR_DEFAULT,
    parameter int               IW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic [N_SRC-1:0] IRQ,
    input  logic             GIE,
    input  logic             INTACK,
    output logic             INTREQ,
    output logic [15:0]      INTVEC,
    output logic [IW-1:0]    ACTIVE_ID,
    output logic [N_SRC-1:0] CLR,
    input  logic [15:0]      MAB,
    input  logic [15:0]      MDBwrite,
    input  logic             MW,
    input  logic             BW,
    output logic [15:0]      MDBread
);

    logic [1:0]       state;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] eligible;
    logic [IW-1:0]    win_idx;
    logic             win_valid;
    logic [15:0]      win_vec;
    logic             unused_bus;

    assign unused_bus = ^{MAB, MDBwrite, MW, BW};

`ifdef INTARB_MASK_EN
    logic        addr_hit;
    logic [15:0] mask_rd;

    assign addr_hit = ((MAB & 16'hFFFE) == MASK_ADDR);

    // Byte writes select a lane by MAB[0]; word writes load every mask bit.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            mask <= '1;
        end else if (MW && addr_hit) begin
            for (int i = 0; i < N_SRC && i < 16; i++) begin
                if (!BW || (MAB[0] == (i >= 8)))
                    mask[i] <= MDBwrite[i];
            end
        end
    end

    always_comb begin
        mask_rd            = '0;
        mask_rd[N_SRC-1:0] = mask;
    end

    assign MDBread = addr_hit ? mask_rd : 16'hzzzz;
`else
    assign mask    = '1;
    assign MDBread = 16'hzzzz;
`endif

    assign eligible = IRQ & mask & (GIE ? {N_SRC{1'b1}} : NMI_MASK);

    prio_enc #(.N_SRC(N_SRC), .IW(IW)) u_prio_enc (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign win_vec = VEC_TOP - 16'(2 * (N_SRC - 1 - int'(win_idx)));

    // The winner registered before an INTACK edge is the one accepted, so a
    // simultaneous higher-priority arrival never displaces it.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            INTREQ    <= 1'b0;
            INTVEC    <= '0;
            ACTIVE_ID <= '0;
            CLR       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    CLR <= '0;
                    if (win_valid) begin
                        ACTIVE_ID <= win_idx;
                        INTVEC    <= win_vec;
                        INTREQ    <= 1'b1;
                        state     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (INTACK) begin
                        CLR            <= '0;
                        CLR[ACTIVE_ID] <= 1'b1;
                        INTREQ         <= 1'b0;
                        state          <= ST_ACK;
                    end else if (!win_valid) begin
                        INTREQ <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        ACTIVE_ID <= win_idx;
                        INTVEC    <= win_vec;
                    end
                end
                ST_ACK: begin
                    CLR   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    CLR    <= '0;
                    INTREQ <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_int_arbiter.sv
// Directed testbench for timer_int_arbiter (N_SRC=8, VEC_TOP=16'hFFFC).
// A second instance with NMI_MASK=0 covers the maskable-only case.
module tb_timer_int_arbiter;

    logic        MCLK;
    logic        reset;
    logic [7:0]  IRQ;
    logic        GIE;
    logic        INTACK;
    logic [15:0] MAB;
    logic [15:0] MDBwrite;
    logic        MW;
    logic        BW;

    logic        INTREQ,  INTREQ2;
    logic [15:0] INTVEC,  INTVEC2;
    logic [2:0]  ACTIVE_ID, ACTIVE_ID2;
    logic [7:0]  CLR,     CLR2;
    wire  [15:0] mdb_read;
    wire  [15:0] unused_mdb2;

    int n_cmp = 0;
    int n_err = 0;

    timer_int_arbiter #(.N_SRC(8), .VEC_TOP(16'hFFFC), .NMI_MASK(8'h80)) dut (
        .MCLK(MCLK), .reset(reset), .IRQ(IRQ), .GIE(GIE), .INTACK(INTACK),
        .INTREQ(INTREQ), .INTVEC(INTVEC), .ACTIVE_ID(ACTIVE_ID), .CLR(CLR),
        .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW), .MDBread(mdb_read)
    );

    timer_int_arbiter #(.N_SRC(8), .VEC_TOP(16'hFFFC), .NMI_MASK(8'h00)) dut_nonmi (
        .MCLK(MCLK), .reset(reset), .IRQ(IRQ), .GIE(GIE), .INTACK(INTACK),
        .INTREQ(INTREQ2), .INTVEC(INTVEC2), .ACTIVE_ID(ACTIVE_ID2), .CLR(CLR2),
        .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW), .MDBread(unused_mdb2)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; IRQ = 8'h00; GIE = 1'b0; INTACK = 1'b0;
        MAB = 16'h0000; MDBwrite = 16'h0000; MW = 1'b0; BW = 1'b0;
        #12;
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL rst_intreq got %b want 0", INTREQ); end
        n_cmp++; if (INTVEC !== 16'h0000) begin n_err++; $display("[TB] FAIL rst_intvec got %h want 0000", INTVEC); end
        n_cmp++; if (ACTIVE_ID !== 3'd0) begin n_err++; $display("[TB] FAIL rst_id got %0d want 0", ACTIVE_ID); end
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL rst_clr got %h want 00", CLR); end
        @(negedge MCLK);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        GIE = 1'b1; IRQ = 8'h04;
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL basic_pre got %b want 0", INTREQ); end
        tick();
        n_cmp++; if (INTREQ !== 1'b1) begin n_err++; $display("[TB] FAIL basic_req got %b want 1", INTREQ); end
        n_cmp++; if (INTVEC !== 16'hFFF2) begin n_err++; $display("[TB] FAIL basic_vec got %h want FFF2", INTVEC); end
        n_cmp++; if (ACTIVE_ID !== 3'd2) begin n_err++; $display("[TB] FAIL basic_id got %0d want 2", ACTIVE_ID); end
        INTACK = 1'b1;
        tick();
        n_cmp++; if (CLR !== 8'h04) begin n_err++; $display("[TB] FAIL basic_clr got %h want 04", CLR); end
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL basic_ack_req got %b want 0", INTREQ); end
        INTACK = 1'b0; IRQ = 8'h00;
        tick();
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL basic_clr_end got %h want 00", CLR); end
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL basic_idle_req got %b want 0", INTREQ); end
    endtask

    task automatic test_back_to_back();
        IRQ = 8'h05;
        tick();
        n_cmp++; if (INTVEC !== 16'hFFF2) begin n_err++; $display("[TB] FAIL b2b_vec1 got %h want FFF2", INTVEC); end
        INTACK = 1'b1;
        tick();
        n_cmp++; if (CLR !== 8'h04) begin n_err++; $display("[TB] FAIL b2b_clr got %h want 04", CLR); end
        INTACK = 1'b0; IRQ = 8'h01;
        tick();
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_gap got %b want 0", INTREQ); end
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL b2b_clr_end got %h want 00", CLR); end
        tick();
        n_cmp++; if (INTREQ !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_req2 got %b want 1", INTREQ); end
        n_cmp++; if (INTVEC !== 16'hFFEE) begin n_err++; $display("[TB] FAIL b2b_vec2 got %h want FFEE", INTVEC); end
        IRQ = 8'h00;
        tick();
    endtask

    task automatic test_preempt();
        IRQ = 8'h02;
        tick();
        n_cmp++; if (INTVEC !== 16'hFFF0) begin n_err++; $display("[TB] FAIL pre_vec1 got %h want FFF0", INTVEC); end
        IRQ = 8'h42;
        tick();
        n_cmp++; if (INTVEC !== 16'hFFFA) begin n_err++; $display("[TB] FAIL pre_vec6 got %h want FFFA", INTVEC); end
        n_cmp++; if (ACTIVE_ID !== 3'd6) begin n_err++; $display("[TB] FAIL pre_id6 got %0d want 6", ACTIVE_ID); end
        n_cmp++; if (INTREQ !== 1'b1) begin n_err++; $display("[TB] FAIL pre_req got %b want 1", INTREQ); end
        INTACK = 1'b1;
        tick();
        n_cmp++; if (CLR !== 8'h40) begin n_err++; $display("[TB] FAIL pre_clr6 got %h want 40", CLR); end
        INTACK = 1'b0; IRQ = 8'h00;
        tick();
        IRQ = 8'h02;
        tick();
        n_cmp++; if (ACTIVE_ID !== 3'd1) begin n_err++; $display("[TB] FAIL pre_id1 got %0d want 1", ACTIVE_ID); end
        IRQ = 8'h42; INTACK = 1'b1;
        tick();
        n_cmp++; if (CLR !== 8'h02) begin n_err++; $display("[TB] FAIL pre_race_clr got %h want 02", CLR); end
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL pre_race_req got %b want 0", INTREQ); end
        INTACK = 1'b0; IRQ = 8'h00;
        tick();
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL pre_race_end got %h want 00", CLR); end
    endtask

    task automatic test_nmi();
        GIE = 1'b0; IRQ = 8'h80;
        tick();
        n_cmp++; if (INTREQ !== 1'b1) begin n_err++; $display("[TB] FAIL nmi_req got %b want 1", INTREQ); end
        n_cmp++; if (INTVEC !== 16'hFFFC) begin n_err++; $display("[TB] FAIL nmi_vec got %h want FFFC", INTVEC); end
        n_cmp++; if (INTREQ2 !== 1'b0) begin n_err++; $display("[TB] FAIL nonmi_req got %b want 0", INTREQ2); end
        IRQ = 8'h00;
        tick();
        GIE = 1'b1; IRQ = 8'h04;
        tick();
        n_cmp++; if (INTREQ !== 1'b1) begin n_err++; $display("[TB] FAIL gie_req got %b want 1", INTREQ); end
        GIE = 1'b0;
        tick();
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL gie_drop got %b want 0", INTREQ); end
        IRQ = 8'h00; GIE = 1'b1;
        tick();
    endtask

    task automatic test_withdraw();
        IRQ = 8'h08;
        tick();
        n_cmp++; if (INTREQ !== 1'b1) begin n_err++; $display("[TB] FAIL wd_req got %b want 1", INTREQ); end
        IRQ = 8'h00;
        tick();
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL wd_drop got %b want 0", INTREQ); end
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL wd_clr got %h want 00", CLR); end
        tick();
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL wd_clr2 got %h want 00", CLR); end
    endtask

    task automatic test_reset_mid_ack();
        IRQ = 8'h10;
        tick();
        INTACK = 1'b1;
        tick();
        n_cmp++; if (CLR !== 8'h10) begin n_err++; $display("[TB] FAIL rma_clr got %h want 10", CLR); end
        reset = 1'b0;
        #1;
        n_cmp++; if (CLR !== 8'h00) begin n_err++; $display("[TB] FAIL rma_clr_rst got %h want 00", CLR); end
        n_cmp++; if (ACTIVE_ID !== 3'd0) begin n_err++; $display("[TB] FAIL rma_id got %0d want 0", ACTIVE_ID); end
        INTACK = 1'b0; IRQ = 8'h00;
        @(negedge MCLK);
        reset = 1'b1;
        tick();
    endtask

`ifdef INTARB_MASK_EN
    task automatic test_mask();
        MAB = 16'h01A0; MDBwrite = 16'h00FB; MW = 1'b1; BW = 1'b0;
        tick();
        MW = 1'b0; IRQ = 8'h04;
        tick();
        n_cmp++; if (INTREQ !== 1'b0) begin n_err++; $display("[TB] FAIL mask_req got %b want 0", INTREQ); end
        #1;
        n_cmp++; if (mdb_read !== 16'h00FB) begin n_err++; $display("[TB] FAIL mask_rd got %h want 00FB", mdb_read); end
        MAB = 16'h0200;
        #1;
        n_cmp++; if (mdb_read !== 16'hzzzz) begin n_err++; $display("[TB] FAIL mask_rd_z got %h want zzzz", mdb_read); end
        IRQ = 8'h00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_preempt();
        test_nmi();
        test_withdraw();
        test_reset_mid_ack();
`ifdef INTARB_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_int_arbiter.md
Name: timer_int_arbiter

Overview:
- Fixed-priority interrupt arbiter/sequencer between the TimerA instances (TAxINT0/TAxINT1 of each timer) and other peripherals, and the CPU's single interrupt-request path.
- Selects the winning source, presents its vector, and waits for the CPU accept handshake.
- On accept, returns a one-cycle clear pulse to the winner (drives TimerA TAxCLR0 for CCR0 sources).
- Sits beside the CPU in the top level, in the MCLK domain.

Parameters:
- N_SRC, 8: number of request inputs; index N_SRC-1 has the highest priority.
- VEC_TOP, 16'hFFFC: vector of source N_SRC-1; source i maps to VEC_TOP - 2*(N_SRC-1-i).
- NMI_MASK, 0 (N_SRC bits): sources whose bit is 1 ignore GIE (non-maskable).
- MASK_ADDR, 16'h01A0: word address of the enable-mask register (used only with INTARB_MASK_EN).

Ports:
- MCLK  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- IRQ  in  N_SRC  level interrupt requests from peripherals.
- GIE  in  1  CPU global interrupt enable (SR.GIE).
- INTACK  in  1  one-cycle CPU pulse: request accepted, vector fetched.
- INTREQ  out  1  interrupt request to the CPU.
- INTVEC  out  16  vector address of the current winner.
- ACTIVE_ID  out  $clog2(N_SRC)  index of the current winner.
- CLR  out  N_SRC  one-hot, one-cycle clear pulse to the accepted source.
- MAB  in  16  memory address bus.
- MDBwrite  in  16  write data.
- MW  in  1  memory write strobe.
- BW  in  1  byte access.
- MDBread  out (wor)  16  read data; 'z when not addressed.

Behaviour:
- Clock and reset: one clock (MCLK). Reset is asynchronous, active-low.
- Reset values: state=IDLE, INTREQ=0, INTVEC=0, ACTIVE_ID=0, CLR=0, mask=all ones.
- Eligible sources: eligible = IRQ & mask & (GIE ? all-ones : NMI_MASK).
- Winner = highest set bit of eligible. Vector is a pure function of the winner index.
- FSM IDLE:
  - If eligible != 0, register the winner, set INTREQ=1, go to PEND.
  - INTREQ rises 1 cycle after IRQ rises.
  - INTACK in IDLE is ignored.
- FSM PEND:
  - Re-arbitrate every cycle. A higher-priority arrival updates ACTIVE_ID/INTVEC on the next edge, and INTREQ stays 1.
  - If eligible becomes 0 (request withdrawn, or GIE drops with no NMI source pending), INTREQ=0 next cycle and go to IDLE.
  - INTACK=1: the winner registered at that edge is accepted. Set CLR[ACTIVE_ID]=1 for exactly the next cycle, INTREQ=0, go to ACK.
  - INTACK and a simultaneous higher-priority arrival in the same cycle: the old winner is accepted.
- FSM ACK (1 cycle):
  - CLR pulse is high.
  - Then go to IDLE; re-arbitration starts in the following cycle.
  - Minimum spacing between two INTREQ assertions is 2 cycles.
  - INTACK in ACK is ignored.
- CLR is never multi-hot and never asserted outside ACK.
- Reset asserted in any state forces reset values immediately (async); no pending CLR pulse survives.

Optional Feature:
- INTARB_MASK_EN defined:
  - Read/write mask register at MASK_ADDR, reset value all ones.
  - Word write loads mask[N_SRC-1:0] from MDBwrite.
  - Byte write to MASK_ADDR loads bits 7:0; byte write to MASK_ADDR+1 loads bits 15:8 (where present).
  - Reads of (MAB & ~1)==MASK_ADDR return the mask zero-extended; otherwise MDBread='z.
  - A mask write takes effect for arbitration in the cycle after the write edge.
- INTARB_MASK_EN not defined:
  - mask is the constant all-ones.
  - MDBread is permanently 'z; bus inputs are unused.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, PEND=1, ACK=2).
  - Default VEC_TOP.
  - MASK_ADDR map constant.
- One sub-module, prio_enc: parameterised N_SRC-bit highest-set-bit encoder with a valid output. It is used for the winner and is reusable elsewhere.

Test Plan (N_SRC=8, VEC_TOP=16'hFFFC):
- Reset with IRQ=8'h00, then GIE=1 and IRQ=8'h04 → INTREQ=1 one cycle later, INTVEC=16'hFFF2, ACTIVE_ID=2. INTACK pulse → CLR=8'h04 for exactly 1 cycle, and INTREQ=0 in that same cycle.
- IRQ=8'h05, GIE=1 → vector 16'hFFF2. Ack, then hold IRQ=8'h01 → INTREQ reasserts 2 cycles after the ack with INTVEC=16'hFFEE.
- In PEND with winner 1, raise IRQ bit 6 → next cycle INTVEC=16'hFFFA. INTACK in the same cycle as the bit-6 rise → CLR=8'h02.
- GIE=0, IRQ=8'h80, NMI_MASK=8'h80 → INTREQ=1 with INTVEC=16'hFFFC. With NMI_MASK=0 → INTREQ stays 0.
- In PEND, drop IRQ to 0 → INTREQ=0 next cycle and no CLR pulse. Assert reset low mid-ACK → CLR=0 immediately.
- With INTARB_MASK_EN: word write 16'h00FB to MASK_ADDR, IRQ=8'h04 → no INTREQ. Read of MASK_ADDR returns 16'h00FB. Read of another address → MDBread='z.
